// File: rtl/ex_muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit (funct3 codes, FSM states, sign fix-up).
package ex_muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } f3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    function automatic logic is_div(f3_e f3);
        return f3[2];
    endfunction

    function automatic logic op1_signed(f3_e f3);
        return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic op2_signed(f3_e f3);
        return f3 inside {F3_MULH, F3_DIV, F3_REM};
    endfunction

    // acc holds {product} for multiplies and {remainder, quotient} for divides.
    function automatic logic [XLEN-1:0] fix_result(f3_e f3, logic [2*XLEN-1:0] acc, logic neg);
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        logic [XLEN-1:0] prod_hi;
        hi = acc[2*XLEN-1:XLEN];
        lo = acc[XLEN-1:0];
        // High word of the 2*XLEN two's-complement negation: ~hi plus the carry out of -lo.
        prod_hi = neg ? (~hi + XLEN'(lo == '0)) : hi;
        case (f3)
            F3_MUL:                        return lo;
            F3_MULH, F3_MULHSU, F3_MULHU:  return prod_hi;
            F3_DIV, F3_DIVU:               return neg ? -lo : lo;
            default:                       return neg ? -hi : hi;
        endcase
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage handshake between the pipeline (ID/EX register, hazard unit) and the RV32M unit.
interface ex_muldiv_if;
    logic                            valid_i;
    logic                            kill_i;
    logic [2:0]                      f3_i;
    logic [ex_muldiv_pkg::XLEN-1:0]  op1_i;
    logic [ex_muldiv_pkg::XLEN-1:0]  op2_i;
    logic                            stall_req_o;
    logic                            done_o;
    logic [ex_muldiv_pkg::XLEN-1:0]  result_o;

    modport master (
        output valid_i, kill_i, f3_i, op1_i, op2_i,
        input  stall_req_o, done_o, result_o
    );

    modport slave (
        input  valid_i, kill_i, f3_i, op1_i, op2_i,
        output stall_req_o, done_o, result_o
    );
endinterface

// File: rtl/ex_muldiv_step.sv
// muldiv_step: one radix-2 iteration -- shift-add for multiplies, shift-subtract-restore for divides.
module muldiv_step
    import ex_muldiv_pkg::*;
(
    input  logic                 is_div,
    input  logic [XLEN-1:0]      opb,
    input  logic [2*XLEN-1:0]    acc,
    output logic [2*XLEN-1:0]    acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            no_borrow;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        sum       = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
        shifted   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        no_borrow = shifted >= {1'b0, opb};
        // Partial remainder stays below the divisor, so the low XLEN bits hold the exact difference.
        diff      = shifted[XLEN-1:0] - opb;
        if (is_div) begin
            if (no_borrow) acc_next = {diff, acc[XLEN-2:0], 1'b1};
            else           acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_next = {sum, acc[XLEN-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit in EX; holds the pipeline via stall_req_o.
// Define MULDIV_FAST_MUL_EN to complete multiplies in one cycle on a combinational multiplier.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ex_muldiv_if.slave    bus
);

    state_e             state, state_next;
    f3_e                f3_q;
    logic               neg_q;
    logic [XLEN-1:0]    opb_q;
    logic [2*XLEN-1:0]  acc_q, acc_next;
    logic [CNT_W-1:0]   count_q;
    logic [XLEN-1:0]    result_q;

    f3_e                f3_in;
    logic               s1, s2, neg_in;
    logic [XLEN-1:0]    mag1, mag2;
    logic               accept, last_step;
    logic               fast_hit;
    logic [XLEN-1:0]    fast_val;

    assign f3_in     = f3_e'(bus.f3_i);
    assign s1        = op1_signed(f3_in) & bus.op1_i[XLEN-1];
    assign s2        = op2_signed(f3_in) & bus.op2_i[XLEN-1];
    assign mag1      = s1 ? -bus.op1_i : bus.op1_i;
    assign mag2      = s2 ? -bus.op2_i : bus.op2_i;
    assign neg_in    = (f3_in == F3_REM) ? s1 : (s1 ^ s2);
    assign accept    = (state == S_IDLE) & bus.valid_i & ~bus.kill_i;
    assign last_step = count_q == CNT_W'(XLEN - 1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_prod;
    assign fast_prod = $signed({s1 | (op1_signed(f3_in) & bus.op1_i[XLEN-1]), bus.op1_i})
                     * $signed({s2 | (op2_signed(f3_in) & bus.op2_i[XLEN-1]), bus.op2_i});
`endif

    // Results known at acceptance: divide by zero and signed overflow (and all multiplies when fast).
    always_comb begin
        fast_hit = 1'b0;
        fast_val = '0;
        if (is_div(f3_in)) begin
            if (bus.op2_i == '0) begin
                fast_hit = 1'b1;
                fast_val = f3_in[1] ? bus.op1_i : '1;
            end else if (op1_signed(f3_in) && bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}
                         && bus.op2_i == '1) begin
                fast_hit = 1'b1;
                fast_val = f3_in[1] ? '0 : bus.op1_i;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            fast_hit = 1'b1;
            fast_val = (f3_in == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    muldiv_step u_step (
        .is_div   (is_div(f3_q)),
        .opb      (opb_q),
        .acc      (acc_q),
        .acc_next (acc_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = fast_hit ? S_DONE : S_CALC;
            S_CALC:  if (last_step) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.kill_i) state_next = S_IDLE;
    end

    assign bus.stall_req_o = accept | ((state == S_CALC) & ~bus.kill_i);
    assign bus.done_o      = (state == S_DONE) & ~bus.kill_i;
    assign bus.result_o    = result_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath is small flops, not a memory, so clearing it on reset is cheap and deterministic.
            state    <= S_IDLE;
            f3_q     <= F3_MUL;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                f3_q    <= f3_in;
                neg_q   <= neg_in;
                opb_q   <= mag2;
                acc_q   <= {{XLEN{1'b0}}, mag1};
                count_q <= '0;
                if (fast_hit) result_q <= fast_val;
            end else if (state == S_CALC && !bus.kill_i) begin
                acc_q   <= acc_next;
                count_q <= count_q + CNT_W'(1);
                if (last_step) result_q <= fix_result(f3_q, acc_next, neg_q);
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, kill/reset aborts, and random ops vs. a model.
`timescale 1ns/1ps
module tb_ex_muldiv;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] last_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M result computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int exp_stalls(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) begin
            if (b == 0) return 1;
            if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Issue one op in the next IDLE cycle, hold it while stalled, check result and stall length.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int n_stall;
        bit got;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.kill_i  = 1'b0;
        bus.f3_i    = f3;
        bus.op1_i   = a;
        bus.op2_i   = b;
        n_stall = 0;
        got     = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            #1;
            if (bus.done_o) begin
                got = 1'b1;
                check({tag, " result"}, bus.result_o, ref_result(f3, a, b));
                check({tag, " stall in done"}, 32'(bus.stall_req_o), 32'd0);
                last_res = ref_result(f3, a, b);
            end else begin
                if (bus.stall_req_o) n_stall++;
                @(negedge clk);
            end
        end
        check({tag, " done seen"}, 32'(got), 32'd1);
        check({tag, " stall cycles"}, n_stall, exp_stalls(f3, a, b));
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.kill_i  = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.f3_i    = 3'd0;
        bus.op1_i   = '0;
        bus.op2_i   = '0;
        last_res    = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset stall", 32'(bus.stall_req_o), 32'd0);
        check("reset done", 32'(bus.done_o), 32'd0);
        check("reset result", bus.result_o, 32'd0);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "MUL 7*-3");
        go_idle();
        #1;
        check("hold result", bus.result_o, 32'hFFFF_FFEB);
        check("idle done", 32'(bus.done_o), 32'd0);

        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULH");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "REM -7/2");
        run_op(3'd5, 32'd100, 32'd7, "DIVU 100/7");
        run_op(3'd7, 32'd100, 32'd7, "REMU 100/7");
        run_op(3'd5, 32'd5, 32'd0, "DIVU 5/0");
        run_op(3'd7, 32'd5, 32'd0, "REMU 5/0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");
        go_idle();

        // Kill a DIV at CALC count 10, then issue a MUL in the following cycle.
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.f3_i    = 3'd4;
        bus.op1_i   = 32'd1000;
        bus.op2_i   = 32'd3;
        repeat (11) @(negedge clk);
        #1;
        check("pre-kill stall", 32'(bus.stall_req_o), 32'd1);
        bus.kill_i = 1'b1;
        #1;
        check("kill stall", 32'(bus.stall_req_o), 32'd0);
        check("kill done", 32'(bus.done_o), 32'd0);
        run_op(3'd0, 32'd12345, 32'd678, "MUL after kill");

        // Two back-to-back ops, then reset in the middle of a third.
        run_op(3'd4, 32'hFFFF_FF00, 32'd9, "b2b DIV");
        run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0000, "b2b MULH");
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.f3_i    = 3'd5;
        bus.op1_i   = 32'd999;
        bus.op2_i   = 32'd4;
        repeat (6) @(negedge clk);
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        #1;
        check("rst stall", 32'(bus.stall_req_o), 32'd0);
        check("rst done", 32'(bus.done_o), 32'd0);
        check("rst result", bus.result_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(f3, a, b, $sformatf("rand%0d f3=%0d", i, f3));
            if (i % 8 == 7) begin
                go_idle();
                #1;
                check("rand hold", bus.result_o, last_res);
            end
        end
        go_idle();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
